// File: rtl/mips_cpu_muldiv_ctrl.sv
// MIPS HI/LO multiply/divide unit: 33-cycle radix-2 shift-add multiply and restoring divide.
// Optional divider datapath is enabled by defining MULDIV_DIV_EN.
module mips_cpu_muldiv_ctrl #(
  parameter logic [31:0] HILO_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic [31:0] a_q, a_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] madd;
  logic [63:0] mul_step;
  logic [63:0] prod;

  assign a_neg = ~op[0] & op_a[31];
  assign b_neg = ~op[0] & op_b[31];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // acc holds {partial product, remaining multiplier bits}; a_q is the multiplicand
  assign madd     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  assign mul_step = {madd, acc_q[31:1]};
  assign prod     = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  logic        rneg_q, rneg_d;
  logic        dz;
  logic [32:0] rsh, rsub;
  logic [63:0] div_step;
  logic [31:0] quo, rem;

  assign dz = (op_b == 32'd0);
  // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
  assign rsh      = {acc_q[63:32], acc_q[31]};
  assign rsub     = rsh - {1'b0, a_q};
  assign div_step = rsub[32] ? {rsh[31:0], acc_q[30:0], 1'b0}
                             : {rsub[31:0], acc_q[30:0], 1'b1};
  assign quo      = neg_q  ? -acc_q[31:0]  : acc_q[31:0];
  assign rem      = rneg_q ? -acc_q[63:32] : acc_q[63:32];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    a_d      = a_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
    rneg_d   = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = op[1];
          cnt_d    = 5'd0;
          neg_d    = a_neg ^ b_neg;
          if (op[1]) begin
`ifdef MULDIV_DIV_EN
            // divide by zero runs on the raw dividend with no sign correction
            neg_d   = (a_neg ^ b_neg) & ~dz;
            rneg_d  = a_neg & ~dz;
            acc_d   = {32'd0, dz ? op_a : a_mag};
            a_d     = b_mag;
            state_d = CALC;
`else
            state_d = FIXUP;
`endif
          end else begin
            a_d     = a_mag;
            acc_d   = {32'd0, b_mag};
            state_d = CALC;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
        acc_d = is_div_q ? div_step : mul_step;
`else
        acc_d = mul_step;
`endif
        if (cnt_q == 5'd31) state_d = FIXUP;
      end
      FIXUP: begin
`ifdef MULDIV_DIV_EN
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          {hi_d, lo_d} = prod;
        end
`else
        // without a divider, a divide waits one extra cycle here and leaves hi/lo alone
        if (is_div_q && cnt_q == 5'd0) begin
          cnt_d = 5'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!is_div_q) {hi_d, lo_d} = prod;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_q      <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= HILO_RESET;
      lo_q     <= HILO_RESET;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV_EN
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Directed bench for mips_cpu_muldiv_ctrl; divide expectations follow MULDIV_DIV_EN.
module tb_mips_cpu_muldiv_ctrl;

  localparam logic [31:0] RST_VAL = 32'h0BAD_F00D;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk, reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] op_a, op_b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  mips_cpu_muldiv_ctrl #(.HILO_RESET(RST_VAL)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_mv(input string tag, input logic h, input logic l, input logic [31:0] wd);
    mthi = h; mtlo = l; wdata = wd;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = wd;
    if (l) m_lo = wd;
    chk({tag, ".hi"}, hi, m_hi);
    chk({tag, ".lo"}, lo, m_lo);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input logic mv);
    start = 1'b1; op = o; op_a = a; op_b = b;
    if (mv) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF; end
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op_a = $urandom; op_b = $urandom;
    chk({tag, ".e0_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".e0_hi"}, hi, m_hi);
    chk({tag, ".e0_lo"}, lo, m_lo);
    for (int i = 1; i < lat; i++) tick();
    chk({tag, ".pre_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".pre_done"}, {31'd0, done}, 32'd0);
    chk({tag, ".pre_hi"}, hi, m_hi);
    chk({tag, ".pre_lo"}, lo, m_lo);
    tick();
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
    m_hi = eh; m_lo = el;
    tick();
    chk({tag, ".done_off"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    m_hi = RST_VAL; m_lo = RST_VAL;
    #12;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.hi", hi, RST_VAL);
    chk("rst.lo", lo, RST_VAL);
    reset = 1'b0;

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    run_op("mult_m3x7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("mult_neg_neg", MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h0000_001E, 33, 1'b0);
    run_op("mult_min", MULT, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0, 33, 1'b0);
    run_op("multu_mv", MULTU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 33, 1'b1);

    // start and mthi mid-operation must both be ignored
    start = 1'b1; op = MULTU; op_a = 32'd2; op_b = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    start = 1'b1; op = MULTU; op_a = 32'd7; op_b = 32'd7; mthi = 1'b1; wdata = 32'h1234;
    tick();
    start = 1'b0; mthi = 1'b0;
    chk("busy_ign.hi_e10", hi, m_hi);
    for (int i = 11; i < 33; i++) tick();
    tick();
    chk("busy_ign.done", {31'd0, done}, 32'd1);
    chk("busy_ign.hi", hi, 32'h0);
    chk("busy_ign.lo", lo, 32'd6);
    m_hi = 32'h0; m_lo = 32'd6;
    tick();
    chk("busy_ign.no_restart", {31'd0, busy}, 32'd0);
    idle_mv("mthi", 1'b1, 1'b0, 32'h1234);
    idle_mv("mthi_mtlo", 1'b1, 1'b1, 32'h5555_AAAA);

`ifdef MULDIV_DIV_EN
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("divu_by0", DIVU, 32'd7, 32'd0, 32'h7, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0);
    run_op("div_100_m7", DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 33, 1'b0);
    run_op("div_m1_by0", DIV, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
    start = 1'b1; op = DIVU; op_a = 32'd100; op_b = 32'd7;
`else
    idle_mv("set_a", 1'b1, 1'b1, 32'hA);
    run_op("divu_off", DIVU, 32'd9, 32'd3, 32'hA, 32'hA, 2, 1'b0);
    run_op("div_off", DIV, 32'hFFFF_FFF9, 32'd2, 32'hA, 32'hA, 2, 1'b0);
    start = 1'b1; op = MULTU; op_a = 32'd100; op_b = 32'd7;
`endif
    // asynchronous reset in the middle of an operation
    tick();
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    tick();
    reset = 1'b1;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.done", {31'd0, done}, 32'd0);
    chk("arst.hi", hi, RST_VAL);
    chk("arst.lo", lo, RST_VAL);
    m_hi = RST_VAL; m_lo = RST_VAL;
    #2;
    reset = 1'b0;
    run_op("after_rst", MULTU, 32'd5, 32'd5, 32'h0, 32'd25, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv_ctrl.md
MIPS_CPU_MULDIV_CTRL -- requirements
Module: mips_cpu_muldiv_ctrl

Interface
REQ-001 SHALL have parameter HILO_RESET, default 32'h0000_0000, reset value of hi and lo.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request new operation; sampled only when busy=0.
REQ-005 SHALL have port op  input  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
REQ-006 SHALL have port op_a  input  32  multiplicand / dividend (rs).
REQ-007 SHALL have port op_b  input  32  multiplier / divisor (rt).
REQ-008 SHALL have port mthi  input  1  write wdata to hi.
REQ-009 SHALL have port mtlo  input  1  write wdata to lo.
REQ-010 SHALL have port wdata  input  32  data for mthi/mtlo.
REQ-011 SHALL have port busy  output  1  high while an operation is in flight; stalls the pipeline.
REQ-012 SHALL have port done  output  1  one-cycle pulse; new hi/lo visible in the same cycle.
REQ-013 SHALL have port hi  output  32  HI register.
REQ-014 SHALL have port lo  output  32  LO register.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIXUP; busy = (state != IDLE), decoded combinationally from registered state.
REQ-016 SHALL, at edge E0 with state=IDLE and start=1, latch op and operand magnitudes (abs value for MULT/DIV, raw for MULTU/DIVU), record result signs, clear the 5-bit iteration counter, and enter CALC.
REQ-017 SHALL, in CALC, perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; after the 32nd step (E32) enter FIXUP.
REQ-018 SHALL, at E33 in FIXUP, write hi/lo, assert done for exactly one cycle, and return to IDLE; start-to-done latency is therefore 33 cycles.
REQ-019 SHALL produce, for multiply, {hi,lo} = 64-bit product; for MULT, the product is negated when the operand signs differ.
REQ-020 SHALL produce, for divide, lo = quotient and hi = remainder; for DIV, the quotient is negated when the signs differ, and the remainder takes the dividend's sign.
REQ-021 SHALL, on divide by zero (op_b=0, DIV or DIVU), still take 33 cycles and give lo=32'hFFFF_FFFF and hi=op_a, with no sign fixup.
REQ-022 SHALL, on DIV 32'h8000_0000 / 32'hFFFF_FFFF, give lo=32'h8000_0000 and hi=32'h0.
REQ-023 SHALL ignore start, mthi and mtlo while busy=1; operands need not be held after E0.
REQ-024 SHALL, in IDLE with start=0, write wdata to hi on mthi and to lo on mtlo at the next edge; both may occur in the same cycle.
REQ-025 SHALL, in IDLE with start=1 and mthi/mtlo also asserted, accept start and discard the moves.
REQ-026 SHALL hold hi/lo unchanged from E0 through E32; old values remain readable during busy.

Reset
REQ-027 SHALL, on reset assertion at any time including mid-CALC/FIXUP, immediately force state=IDLE, busy=0, done=0, counter=0, hi=lo=HILO_RESET; the aborted operation is discarded.
REQ-028 SHALL accept start on the first edge after reset deassertion.

Configuration
REQ-029 SHALL, with macro MULDIV_DIV_EN defined, implement DIV/DIVU as specified above.
REQ-030 SHALL, without MULDIV_DIV_EN, omit the divider datapath entirely; DIV/DIVU starts enter FIXUP directly, pulse done at E2, and leave hi/lo unchanged. Multiply behaviour is unaffected.

Verification
REQ-031 SHALL cover: MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> at E33 hi=32'hFFFF_FFFE, lo=32'h0000_0001, done high one cycle, busy high E0..E33.
REQ-032 SHALL cover: MULT -3 x 7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-033 SHALL cover: DIV -7 / 2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU 7 / 0 -> lo=32'hFFFF_FFFF, hi=32'h7.
REQ-034 SHALL cover: start and mthi(wdata=32'h1234) pulsed at E10 during a MULTU 2x3 -> both ignored; result hi=0, lo=6; a subsequent IDLE mthi sets hi=32'h1234.
REQ-035 SHALL cover: reset asserted at E15 of a DIVU -> busy=0 and hi=lo=HILO_RESET without waiting for a clock edge; a new MULTU 5x5 gives lo=25 at its own E33.
REQ-036 SHALL cover: build without MULDIV_DIV_EN, DIVU 9/3 with hi=lo=32'hA -> done at E2, hi=lo=32'hA, busy low from E2.
